// File: rtl/prog_pkg.sv
// Shared types and default sizes for the program loader ROM.
// The optional load checksum is enabled with the PROG_CKSUM_EN macro.
package prog_pkg;

    localparam int PROG_ADDR_W = 4;
    localparam int PROG_DATA_W = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } prog_state_t;

endpackage

// File: rtl/prog_mem_array.sv
// Instruction storage: synchronous write, asynchronous clear, combinational read.
// Kept in flops because the whole array must clear on reset.
module prog_mem_array #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/prog_loader_rom.sv
// Loadable instruction store: streams a program in, holds the CPU while loading, then serves reads.
// Define PROG_CKSUM_EN to add load_cksum, the XOR of all words accepted in the current load.
module prog_loader_rom
    import prog_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DATA_W = PROG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              load_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
`ifdef PROG_CKSUM_EN
    output logic [DATA_W-1:0] load_cksum,
`endif
    output logic              cpu_hold
);

    localparam int DEPTH = 2 ** ADDR_W;

    prog_state_t       r_state;
    prog_state_t       w_state_next;
    // One spare bit so the pointer never wraps after the last word.
    logic [ADDR_W:0]   r_wptr;
    logic              w_beat;
    logic              w_final;
    logic              w_enter_load;
    logic [DATA_W-1:0] w_rdata;

    assign w_beat       = load_valid & load_ready;
    assign w_final      = w_beat & (load_last | (r_wptr == (ADDR_W+1)'(DEPTH - 1)));
    assign w_enter_load = (r_state != LOAD) && (w_state_next == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (load_start) w_state_next = LOAD;
            LOAD:    if (w_final)    w_state_next = RUN;
            RUN:     if (load_start) w_state_next = LOAD;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (r_state == LOAD);
        cpu_hold   = (r_state != RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_enter_load) begin
            r_wptr <= '0;
        end else if (w_beat) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_beat),
        .waddr (r_wptr[ADDR_W-1:0]),
        .wdata (load_data),
        .raddr (addr),
        .rdata (w_rdata)
    );

    // The CPU sees NOP whenever it is not running.
    assign data = (r_state == RUN) ? w_rdata : '0;

`ifdef PROG_CKSUM_EN
    logic [DATA_W-1:0] r_cksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cksum <= '0;
        end else if (w_enter_load) begin
            r_cksum <= '0;
        end else if (w_beat) begin
            r_cksum <= r_cksum ^ load_data;
        end
    end

    assign load_cksum = r_cksum;
`endif

endmodule
